// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU control encodings, opcodes, multiplier states
// and the forwarding-hit helper used by the execute stage.
package cpu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_MUL = 4'b1000;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mulState_e;

  // A later stage supplies src when it writes a matching, non-zero register.
  function automatic logic fwdHit(input logic regWrite, input logic [4:0] dst,
                                  input logic [4:0] src);
    return regWrite && (dst != 5'd0) && (dst == src);
  endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: one partial product per cycle, low DATA_W
// bits of the unsigned product, operands captured once at start.
module seq_multiplier #(
  parameter int DATA_W   = 32,
  parameter int MUL_ITER = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] product
);
  import cpu_pkg::*;

  localparam int CNT_W = $clog2(MUL_ITER);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MUL_ITER - 1);

  mulState_e         state_r, stateNext_s;
  logic [CNT_W-1:0]  count_r;
  logic [DATA_W-1:0] mcand_r, mplier_r, acc_r;

  // State register and shift-add datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= MUL_IDLE;
      count_r  <= {CNT_W{1'b0}};
      mcand_r  <= {DATA_W{1'b0}};
      mplier_r <= {DATA_W{1'b0}};
      acc_r    <= {DATA_W{1'b0}};
    end else begin
      state_r <= stateNext_s;
      case (state_r)
        MUL_IDLE: begin
          if (start) begin
            mcand_r  <= a;
            mplier_r <= b;
            acc_r    <= {DATA_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
          end
        end
        MUL_BUSY: begin
          if (mplier_r[0]) begin
            acc_r <= acc_r + mcand_r;
          end
          mcand_r  <= {mcand_r[DATA_W-2:0], 1'b0};
          mplier_r <= {1'b0, mplier_r[DATA_W-1:1]};
          count_r  <= count_r + CNT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state and status decode; no stall is requested while in reset.
  always_comb begin
    stateNext_s = state_r;
    busy        = 1'b0;
    done        = 1'b0;
    case (state_r)
      MUL_IDLE: begin
        if (start) begin
          stateNext_s = MUL_BUSY;
          busy        = rst_n;
        end else begin
          stateNext_s = MUL_IDLE;
        end
      end
      MUL_BUSY: begin
        busy = 1'b1;
        if (count_r == LAST_CNT) begin
          stateNext_s = MUL_DONE;
        end else begin
          stateNext_s = MUL_BUSY;
        end
      end
      MUL_DONE: begin
        done        = 1'b1;
        stateNext_s = MUL_IDLE;
      end
      default: begin
        stateNext_s = MUL_IDLE;
      end
    endcase
  end

  assign product = acc_r;

endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage with operand forwarding, ALU, iterative multiplier and the
// EX/MEM pipeline register feeding the memory stage.
module ex_mem_stage #(
  parameter int DATA_W   = 32,
  parameter int MUL_ITER = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       instructionEX,
  input  logic [DATA_W-1:0] EXread1,
  input  logic [DATA_W-1:0] EXread2,
  input  logic [DATA_W-1:0] EXsignEx,
  input  logic              EXMemRead,
  input  logic              EXMemToReg,
  input  logic              EXMemWrite,
  input  logic              EXRegWrite,
  input  logic [4:0]        EXwriteReg,
  input  logic [3:0]        EXAluCtrl,
  input  logic              WBRegWrite,
  input  logic [4:0]        WBwriteReg,
  input  logic [DATA_W-1:0] WBwriteData,
  output logic              ex_stall,
  output logic              MEMMemRead,
  output logic              MEMMemToReg,
  output logic              MEMMemWrite,
  output logic              MEMRegWrite,
  output logic [4:0]        MEMwriteReg,
  output logic [DATA_W-1:0] MEMaluResult,
  output logic [DATA_W-1:0] MEMstoreData,
  output logic [31:0]       instructionMEM
);
  import cpu_pkg::*;

  logic [4:0]        rs_s, rt_s;
  logic [5:0]        opcode_s;
  logic [DATA_W-1:0] fwdA_s, fwdB_s, opB_s, aluResult_s, mulProduct_s;
  logic              mulStart_s, mulBusy_s, mulDone_s;

  assign rs_s       = instructionEX[25:21];
  assign rt_s       = instructionEX[20:16];
  assign opcode_s   = instructionEX[31:26];
  assign mulStart_s = (EXAluCtrl == ALU_MUL);
  assign ex_stall   = mulBusy_s;

  // Operand forwarding; the younger MEM result shadows WB.
  always_comb begin
    fwdA_s = EXread1;
    fwdB_s = EXread2;
    if (fwdHit(MEMRegWrite, MEMwriteReg, rs_s)) begin
      fwdA_s = MEMaluResult;
    end else if (fwdHit(WBRegWrite, WBwriteReg, rs_s)) begin
      fwdA_s = WBwriteData;
    end else begin
      fwdA_s = EXread1;
    end
    if (fwdHit(MEMRegWrite, MEMwriteReg, rt_s)) begin
      fwdB_s = MEMaluResult;
    end else if (fwdHit(WBRegWrite, WBwriteReg, rt_s)) begin
      fwdB_s = WBwriteData;
    end else begin
      fwdB_s = EXread2;
    end
    if (opcode_s == OPC_RTYPE) begin
      opB_s = fwdB_s;
    end else begin
      opB_s = EXsignEx;
    end
  end

  seq_multiplier #(
    .DATA_W  (DATA_W),
    .MUL_ITER(MUL_ITER)
  ) uMul (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (mulStart_s),
    .a      (fwdA_s),
    .b      (opB_s),
    .busy   (mulBusy_s),
    .done   (mulDone_s),
    .product(mulProduct_s)
  );

  // ALU; a MUL only reaches EX/MEM in the multiplier's DONE cycle.
  always_comb begin
    aluResult_s = {DATA_W{1'b0}};
    case (EXAluCtrl)
      ALU_AND: aluResult_s = fwdA_s & opB_s;
      ALU_OR:  aluResult_s = fwdA_s | opB_s;
      ALU_ADD: aluResult_s = fwdA_s + opB_s;
      ALU_SUB: aluResult_s = fwdA_s - opB_s;
      ALU_NOR: aluResult_s = ~(fwdA_s | opB_s);
      ALU_SLT: begin
        if ($signed(fwdA_s) < $signed(opB_s)) begin
          aluResult_s = {{(DATA_W-1){1'b0}}, 1'b1};
        end else begin
          aluResult_s = {DATA_W{1'b0}};
        end
      end
      ALU_MUL: begin
        if (mulDone_s) begin
          aluResult_s = mulProduct_s;
        end else begin
          aluResult_s = {DATA_W{1'b0}};
        end
      end
      default: aluResult_s = {DATA_W{1'b0}};
    endcase
  end

  // EX/MEM register; stalled cycles inject a bubble with all controls cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      MEMMemRead     <= 1'b0;
      MEMMemToReg    <= 1'b0;
      MEMMemWrite    <= 1'b0;
      MEMRegWrite    <= 1'b0;
      MEMwriteReg    <= 5'd0;
      MEMaluResult   <= {DATA_W{1'b0}};
      MEMstoreData   <= {DATA_W{1'b0}};
      instructionMEM <= 32'd0;
    end else if (ex_stall) begin
      MEMMemRead     <= 1'b0;
      MEMMemToReg    <= 1'b0;
      MEMMemWrite    <= 1'b0;
      MEMRegWrite    <= 1'b0;
      MEMwriteReg    <= 5'd0;
      instructionMEM <= 32'd0;
    end else begin
      MEMMemRead     <= EXMemRead;
      MEMMemToReg    <= EXMemToReg;
      MEMMemWrite    <= EXMemWrite;
      MEMRegWrite    <= EXRegWrite && (EXwriteReg != 5'd0);
      MEMwriteReg    <= EXwriteReg;
      MEMaluResult   <= aluResult_s;
      MEMstoreData   <= fwdB_s;
      instructionMEM <= instructionEX;
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: expected EX/MEM contents are queued when
// an instruction is issued and compared when that instruction leaves EX.
module tb_ex_mem_stage;
  import cpu_pkg::*;

  logic        clk, rst_n;
  logic [31:0] instructionEX, EXread1, EXread2, EXsignEx, WBwriteData;
  logic        EXMemRead, EXMemToReg, EXMemWrite, EXRegWrite, WBRegWrite;
  logic [4:0]  EXwriteReg, WBwriteReg;
  logic [3:0]  EXAluCtrl;
  logic        ex_stall, MEMMemRead, MEMMemToReg, MEMMemWrite, MEMRegWrite;
  logic [4:0]  MEMwriteReg;
  logic [31:0] MEMaluResult, MEMstoreData, instructionMEM;

  ex_mem_stage #(.DATA_W(32), .MUL_ITER(32)) dut (
    .clk(clk), .rst_n(rst_n), .instructionEX(instructionEX),
    .EXread1(EXread1), .EXread2(EXread2), .EXsignEx(EXsignEx),
    .EXMemRead(EXMemRead), .EXMemToReg(EXMemToReg), .EXMemWrite(EXMemWrite),
    .EXRegWrite(EXRegWrite), .EXwriteReg(EXwriteReg), .EXAluCtrl(EXAluCtrl),
    .WBRegWrite(WBRegWrite), .WBwriteReg(WBwriteReg), .WBwriteData(WBwriteData),
    .ex_stall(ex_stall), .MEMMemRead(MEMMemRead), .MEMMemToReg(MEMMemToReg),
    .MEMMemWrite(MEMMemWrite), .MEMRegWrite(MEMRegWrite), .MEMwriteReg(MEMwriteReg),
    .MEMaluResult(MEMaluResult), .MEMstoreData(MEMstoreData),
    .instructionMEM(instructionMEM)
  );

  typedef struct {
    logic [31:0] res;
    logic [31:0] store;
    logic [4:0]  wreg;
    logic        regWr;
    logic [2:0]  ctl;
    logic [31:0] instr;
  } exp_t;

  exp_t sbQ[$];
  exp_t e;
  int   nCompared = 0;
  int   nMismatch = 0;
  int   bubbleCnt = 0;
  logic stallPrev = 1'b0;
  logic validPrev = 1'b0;
  logic opValid   = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatch++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] opc, input logic [4:0] rs,
                                     input logic [4:0] rt);
    return {opc, rs, rt, 16'hA5A5};
  endfunction

  always @(negedge clk) begin
    stallPrev = ex_stall;
    validPrev = opValid;
  end

  // Output monitor: bubbles while stalled, scoreboard pop when an op retires.
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (stallPrev) begin
        bubbleCnt++;
        checkVal("bubble_regwr", 32'(MEMRegWrite), 32'd0);
        checkVal("bubble_instr", instructionMEM, 32'd0);
      end else if (validPrev) begin
        if (sbQ.size() == 0) begin
          checkVal("sb_empty", 32'd1, 32'd0);
        end else begin
          e = sbQ.pop_front();
          checkVal("alu_result", MEMaluResult, e.res);
          checkVal("store_data", MEMstoreData, e.store);
          checkVal("write_reg", 32'(MEMwriteReg), 32'(e.wreg));
          checkVal("reg_write", 32'(MEMRegWrite), 32'(e.regWr));
          checkVal("mem_ctl", 32'({MEMMemRead, MEMMemToReg, MEMMemWrite}), 32'(e.ctl));
          checkVal("instr_mem", instructionMEM, e.instr);
        end
      end
    end
  end

  task automatic setWb(input logic rw, input logic [4:0] r, input logic [31:0] d);
    WBRegWrite  = rw;
    WBwriteReg  = r;
    WBwriteData = d;
  endtask

  task automatic sendOp(input logic [31:0] instr, input logic [31:0] r1, input logic [31:0] r2,
                        input logic [31:0] imm, input logic [3:0] ctrl, input logic [4:0] wreg,
                        input logic rw, input logic [2:0] ctl, input logic [31:0] expRes,
                        input logic [31:0] expStore, input int expStall, input string tag);
    exp_t x;
    int   stalls = 0;
    int   guard  = 0;
    logic st;
    instructionEX = instr;
    EXread1 = r1;
    EXread2 = r2;
    EXsignEx = imm;
    EXAluCtrl = ctrl;
    EXwriteReg = wreg;
    EXRegWrite = rw;
    {EXMemRead, EXMemToReg, EXMemWrite} = ctl;
    opValid = 1'b1;
    x.res = expRes;
    x.store = expStore;
    x.wreg = wreg;
    x.regWr = rw && (wreg != 5'd0);
    x.ctl = ctl;
    x.instr = instr;
    sbQ.push_back(x);
    do begin
      @(negedge clk);
      st = ex_stall;
      @(posedge clk);
      if (st) stalls++;
      guard++;
    end while (st && guard < 100);
    if (guard >= 100) checkVal({tag, "_timeout"}, 32'd1, 32'd0);
    checkVal({tag, "_stall_cycles"}, 32'(stalls), 32'(expStall));
    #2;
  endtask

  task automatic idle(input int n);
    opValid = 1'b0;
    instructionEX = 32'd0;
    {EXRegWrite, EXMemRead, EXMemToReg, EXMemWrite} = 4'd0;
    EXwriteReg = 5'd0;
    EXAluCtrl = ALU_AND;
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int b0;
    rst_n = 1'b0;
    instructionEX = 32'd0; EXread1 = 32'd0; EXread2 = 32'd0; EXsignEx = 32'd0;
    {EXMemRead, EXMemToReg, EXMemWrite, EXRegWrite} = 4'd0;
    EXwriteReg = 5'd0; EXAluCtrl = ALU_AND;
    setWb(1'b0, 5'd0, 32'd0);
    #1;
    checkVal("rst_regwr", 32'(MEMRegWrite), 32'd0);
    checkVal("rst_result", MEMaluResult, 32'd0);
    checkVal("rst_instr", instructionMEM, 32'd0);
    checkVal("rst_stall", 32'(ex_stall), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    sendOp(mk(OPC_RTYPE, 5'd1, 5'd2), 32'd5, 32'd7, 32'd0, ALU_ADD, 5'd3, 1'b1, 3'b000, 32'd12, 32'd7, 0, "add");
    sendOp(mk(OPC_RTYPE, 5'd3, 5'd4), 32'd0, 32'd2, 32'd0, ALU_SUB, 5'd5, 1'b1, 3'b000, 32'd10, 32'd2, 0, "sub_memfwd");
    sendOp(mk(OPC_RTYPE, 5'd1, 5'd2), 32'd5, 32'd7, 32'd0, ALU_ADD, 5'd3, 1'b1, 3'b000, 32'd12, 32'd7, 0, "add2");
    setWb(1'b1, 5'd3, 32'd99);
    sendOp(mk(OPC_RTYPE, 5'd3, 5'd4), 32'd0, 32'd2, 32'd0, ALU_SUB, 5'd5, 1'b1, 3'b000, 32'd10, 32'd2, 0, "sub_mem_over_wb");
    setWb(1'b1, 5'd6, 32'd40);
    sendOp(mk(OPC_RTYPE, 5'd6, 5'd7), 32'd0, 32'd1, 32'd0, ALU_ADD, 5'd8, 1'b1, 3'b000, 32'd41, 32'd1, 0, "add_wbfwd");
    setWb(1'b0, 5'd0, 32'd0);
    sendOp(mk(6'b001010, 5'd9, 5'd10), 32'hFFFF_FFFF, 32'd0, 32'd1, ALU_SLT, 5'd11, 1'b1, 3'b000, 32'd1, 32'd0, 0, "slti");
    sendOp(mk(6'b001100, 5'd12, 5'd13), 32'h0000_F0F0, 32'd0, 32'h0000_0FF0, ALU_AND, 5'd0, 1'b1, 3'b000, 32'h0000_00F0, 32'd0, 0, "andi_r0");
    sendOp(mk(OPC_RTYPE, 5'd14, 5'd15), 32'h0000_F000, 32'h0000_000F, 32'd0, ALU_OR, 5'd16, 1'b1, 3'b000, 32'h0000_F00F, 32'h0000_000F, 0, "or");
    sendOp(mk(OPC_RTYPE, 5'd17, 5'd18), 32'h0F0F_0000, 32'h0000_00F0, 32'd0, ALU_NOR, 5'd19, 1'b1, 3'b000, 32'hF0F0_FF0F, 32'h0000_00F0, 0, "nor");
    sendOp(mk(OPC_RTYPE, 5'd20, 5'd21), 32'd1, 32'd2, 32'd0, 4'b0011, 5'd22, 1'b1, 3'b000, 32'd0, 32'd2, 0, "bad_ctrl");
    sendOp(mk(6'b101011, 5'd23, 5'd24), 32'h0000_0100, 32'h0000_DEAD, 32'd8, ALU_ADD, 5'd0, 1'b0, 3'b001, 32'h0000_0108, 32'h0000_DEAD, 0, "store");
    sendOp(mk(OPC_RTYPE, 5'd25, 5'd26), 32'hFFFF_FFFF, 32'd2, 32'd0, ALU_ADD, 5'd27, 1'b1, 3'b000, 32'd1, 32'd2, 0, "add_wrap");

    b0 = bubbleCnt;
    fork
      sendOp(mk(OPC_RTYPE, 5'd28, 5'd29), 32'h0001_0003, 32'd5, 32'd0, ALU_MUL, 5'd30, 1'b1, 3'b000, 32'h0005_000F, 32'd5, 33, "mul");
      begin
        repeat (6) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
          #3 setWb(1'b1, (i % 2 == 0) ? 5'd28 : 5'd29, $urandom);
          @(posedge clk);
        end
        #3 setWb(1'b0, 5'd0, 32'd0);
      end
    join
    checkVal("mul_bubbles", 32'(bubbleCnt - b0), 32'd33);

    b0 = bubbleCnt;
    sendOp(mk(OPC_RTYPE, 5'd14, 5'd15), 32'hFFFF_FFFF, 32'd2, 32'd0, ALU_MUL, 5'd16, 1'b1, 3'b000, 32'hFFFF_FFFE, 32'd2, 33, "mul_b2b_1");
    sendOp(mk(OPC_RTYPE, 5'd17, 5'd18), 32'd3, 32'd3, 32'd0, ALU_MUL, 5'd19, 1'b1, 3'b000, 32'd9, 32'd3, 33, "mul_b2b_2");
    checkVal("b2b_bubbles", 32'(bubbleCnt - b0), 32'd66);

    // Multiply aborted by reset during BUSY; nothing is queued for it.
    instructionEX = mk(OPC_RTYPE, 5'd1, 5'd2);
    EXread1 = 32'd7; EXread2 = 32'd9; EXAluCtrl = ALU_MUL;
    EXwriteReg = 5'd4; EXRegWrite = 1'b1;
    repeat (11) @(posedge clk);
    #2;
    checkVal("pre_rst_stall", 32'(ex_stall), 32'd1);
    rst_n = 1'b0;
    opValid = 1'b0;
    #1;
    checkVal("abort_stall", 32'(ex_stall), 32'd0);
    checkVal("abort_regwr", 32'(MEMRegWrite), 32'd0);
    checkVal("abort_wreg", 32'(MEMwriteReg), 32'd0);
    checkVal("abort_result", MEMaluResult, 32'd0);
    checkVal("abort_store", MEMstoreData, 32'd0);
    checkVal("abort_instr", instructionMEM, 32'd0);
    idle(1);
    rst_n = 1'b1;
    sendOp(mk(OPC_RTYPE, 5'd1, 5'd2), 32'd1, 32'd2, 32'd0, ALU_ADD, 5'd3, 1'b1, 3'b000, 32'd3, 32'd2, 0, "add_after_rst");
    idle(2);
    checkVal("sb_drained", 32'(sbQ.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
